axis_unpack: RTL and testbench



---
 rtl/axis_unpack.sv | 83 ++++++++
 tb/tb_axis_unpack.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_unpack.sv
// axis_unpack: wide-to-narrow AXI-stream width converter.
// Splits one RATIO*DATA_WIDTH word into RATIO beats, LSB slice first.
module axis_unpack #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [RATIO*DATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready
);

  localparam int W  = RATIO * DATA_WIDTH;
  localparam int CW = $clog2(RATIO + 1);

  localparam logic [CW-1:0] REM_FULL = CW'(RATIO);
  localparam logic [CW-1:0] REM_ONE  = CW'(1);
  localparam logic [CW-1:0] REM_ZERO = '0;

  logic [W-1:0]  sh;
  logic [CW-1:0] rem;

  logic [W-1:0]  sh_nxt;
  logic [CW-1:0] rem_nxt;
  logic [CW-1:0] rem_dec;
  logic          valid_nxt;
  logic          last_nxt;

  logic accept;
  logic beat;

  // Ready only when nothing is owed, or the final beat leaves this cycle.
  assign s_tready = (rem == REM_ZERO) ||
                    ((rem == REM_ONE) && m_tready);

  assign accept  = s_tvalid && s_tready;
  assign beat    = m_tvalid && m_tready;
  assign rem_dec = rem - REM_ONE;

  assign m_tdata = sh[DATA_WIDTH-1:0];

  // Next-state: a new word wins over the last beat; the shift is
  // skipped on the final beat so m_tdata holds while idle.
  always_comb begin
    sh_nxt    = sh;
    rem_nxt   = rem;
    valid_nxt = m_tvalid;
    last_nxt  = m_tlast;
    if (accept) begin
      sh_nxt    = s_tdata;
      rem_nxt   = REM_FULL;
      valid_nxt = 1'b1;
      last_nxt  = (RATIO == 1);
    end else if (beat) begin
      if (rem > REM_ONE)
        sh_nxt = sh >> DATA_WIDTH;
      rem_nxt   = rem_dec;
      valid_nxt = (rem_dec != REM_ZERO);
      last_nxt  = (rem_dec == REM_ONE);
    end
  end

  // State registers; reset drops any partially emitted word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh       <= '0;
      rem      <= REM_ZERO;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      sh       <= sh_nxt;
      rem      <= rem_nxt;
      m_tvalid <= valid_nxt;
      m_tlast  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_axis_unpack.sv
// tb_axis_unpack: directed and randomised checks of axis_unpack
// in three builds (8x4, 8x1, 5x3) against a queue-based model.
module tb_axis_unpack;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // build A: DATA_WIDTH=8, RATIO=4
  logic [31:0] a_s_tdata = '0;
  logic        a_s_tvalid = 1'b0;
  logic        a_s_tready;
  logic [7:0]  a_m_tdata;
  logic        a_m_tvalid;
  logic        a_m_tlast;
  logic        a_m_tready = 1'b0;

  // build B: DATA_WIDTH=8, RATIO=1
  logic [7:0]  b_s_tdata = '0;
  logic        b_s_tvalid = 1'b0;
  logic        b_s_tready;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid;
  logic        b_m_tlast;
  logic        b_m_tready = 1'b0;

  // build C: DATA_WIDTH=5, RATIO=3
  logic [14:0] c_s_tdata = '0;
  logic        c_s_tvalid = 1'b0;
  logic        c_s_tready;
  logic [4:0]  c_m_tdata;
  logic        c_m_tvalid;
  logic        c_m_tlast;
  logic        c_m_tready = 1'b0;

  axis_unpack #(.DATA_WIDTH(8), .RATIO(4)) dut_a (
    .clock(clock), .reset(reset),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast),
    .m_tready(a_m_tready)
  );

  axis_unpack #(.DATA_WIDTH(8), .RATIO(1)) dut_b (
    .clock(clock), .reset(reset),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast),
    .m_tready(b_m_tready)
  );

  axis_unpack #(.DATA_WIDTH(5), .RATIO(3)) dut_c (
    .clock(clock), .reset(reset),
    .s_tdata(c_s_tdata), .s_tvalid(c_s_tvalid), .s_tready(c_s_tready),
    .m_tdata(c_m_tdata), .m_tvalid(c_m_tvalid), .m_tlast(c_m_tlast),
    .m_tready(c_m_tready)
  );

  // Held data while a beat is stalled must not change.
  a_c_stable: assert property (@(posedge clock) disable iff (reset)
    (c_m_tvalid && !c_m_tready) |=> $stable(c_m_tdata));

  task automatic check_a_idle(input string tag, input logic [7:0] d);
    checks++;
    if (a_m_tvalid !== 1'b0 || a_m_tlast !== 1'b0 ||
        a_m_tdata !== d || a_s_tready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v=%b l=%b d=%h r=%b want v=0 l=0 d=%h r=1",
               tag, a_m_tvalid, a_m_tlast, a_m_tdata, a_s_tready, d);
    end
  endtask

  task automatic check_a_beat(input string tag, input logic [7:0] d,
                              input logic l, input logic r);
    checks++;
    if (a_m_tvalid !== 1'b1 || a_m_tdata !== d ||
        a_m_tlast !== l || a_s_tready !== r) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h l=%b r=%b want v=1 d=%h l=%b r=%b",
               tag, a_m_tvalid, a_m_tdata, a_m_tlast, a_s_tready, d, l, r);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_a_idle("reset_held", 8'h00);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check_a_idle("after_reset", 8'h00);
    // mid-word reset
    a_m_tready = 1'b1;
    a_s_tdata  = 32'hA4A3A2A1;
    a_s_tvalid = 1'b1;
    @(negedge clock);
    a_s_tvalid = 1'b0;
    #1;
    check_a_beat("mid_pre0", 8'hA1, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    check_a_beat("mid_pre1", 8'hA2, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_a_idle("mid_async", 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_a_idle("mid_after", 8'h00);
  endtask

  task automatic test_single_word;
    logic [31:0] w;
    w = 32'h44332211;
    @(negedge clock);
    a_m_tready = 1'b1;
    a_s_tdata  = w;
    a_s_tvalid = 1'b1;
    @(negedge clock);
    a_s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      check_a_beat($sformatf("single_b%0d", i), 8'(w >> (8 * i)),
                   (i == 3), (i == 3));
    end
    @(negedge clock);
    #1;
    check_a_idle("single_empty", 8'h44);
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    a_m_tready = 1'b1;
    a_s_tdata  = 32'h04030201;
    a_s_tvalid = 1'b1;
    @(negedge clock);
    a_s_tdata = 32'h08070605;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 4) a_s_tvalid = 1'b0;
      #1;
      check_a_beat($sformatf("b2b_b%0d", i), 8'(i + 1),
                   (i == 3 || i == 7), (i == 3 || i == 7));
    end
    @(negedge clock);
    #1;
    check_a_idle("b2b_empty", 8'h08);
  endtask

  task automatic test_backpressure;
    @(negedge clock);
    a_m_tready = 1'b1;
    a_s_tdata  = 32'h44332211;
    a_s_tvalid = 1'b1;
    @(negedge clock);
    a_s_tvalid = 1'b0;
    #1;
    check_a_beat("bp_b0", 8'h11, 1'b0, 1'b0);
    @(negedge clock);
    a_m_tready = 1'b0;
    a_s_tdata  = 32'hDEADBEEF;
    a_s_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      check_a_beat($sformatf("bp_stall%0d", k), 8'h22, 1'b0, 1'b0);
    end
    @(negedge clock);
    a_m_tready = 1'b1;
    a_s_tvalid = 1'b0;
    #1;
    check_a_beat("bp_release", 8'h22, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    check_a_beat("bp_b2", 8'h33, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    check_a_beat("bp_b3", 8'h44, 1'b1, 1'b1);
    @(negedge clock);
    #1;
    check_a_idle("bp_empty", 8'h44);
  endtask

  task automatic test_ratio1_random;
    logic [7:0] q[$];
    int   sent;
    int   cyc;
    bit   acc;
    logic exp_r;
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (acc) b_s_tvalid = 1'b0;
      if (!b_s_tvalid && sent < 1000 && $urandom_range(1) == 1) begin
        b_s_tdata  = 8'($urandom);
        b_s_tvalid = 1'b1;
      end
      b_m_tready = 1'($urandom_range(1));
      #1;
      exp_r = (q.size() == 0) || b_m_tready;
      checks++;
      if (b_s_tready !== exp_r || b_m_tvalid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL r1_hs: got r=%b v=%b want r=%b v=%b",
                 b_s_tready, b_m_tvalid, exp_r, (q.size() != 0));
      end
      if (q.size() != 0) begin
        checks++;
        if (b_m_tdata !== q[0] || b_m_tlast !== 1'b1) begin
          errors++;
          $display("FAIL r1_beat: got d=%h l=%b want d=%h l=1",
                   b_m_tdata, b_m_tlast, q[0]);
        end
        if (b_m_tready) void'(q.pop_front());
      end
      acc = b_s_tvalid && exp_r;
      if (acc) begin
        q.push_back(b_s_tdata);
        sent++;
      end
    end
    b_s_tvalid = 1'b0;
    b_m_tready = 1'b0;
    checks++;
    if (cyc >= 20000 || sent != 1000) begin
      errors++;
      $display("FAIL r1_done: got sent=%0d cyc=%0d want sent=1000 cyc<20000",
               sent, cyc);
    end
  endtask

  task automatic test_ratio3_random;
    logic [4:0] qd[$];
    bit         ql[$];
    int         sent;
    int         cyc;
    bit         acc;
    bit         prev_stall;
    logic [4:0] prev_d;
    logic       exp_r;
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    prev_stall = 1'b0;
    prev_d = '0;
    while ((sent < 500 || qd.size() != 0) && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (prev_stall) begin
        checks++;
        if (c_m_tdata !== prev_d) begin
          errors++;
          $display("FAIL r3_stall: got d=%h want d=%h", c_m_tdata, prev_d);
        end
      end
      if (acc) c_s_tvalid = 1'b0;
      if (!c_s_tvalid && sent < 500 && $urandom_range(1) == 1) begin
        c_s_tdata  = 15'($urandom);
        c_s_tvalid = 1'b1;
      end
      c_m_tready = 1'($urandom_range(1));
      #1;
      exp_r = (qd.size() == 0) || (qd.size() == 1 && c_m_tready);
      checks++;
      if (c_s_tready !== exp_r || c_m_tvalid !== (qd.size() != 0)) begin
        errors++;
        $display("FAIL r3_hs: got r=%b v=%b want r=%b v=%b",
                 c_s_tready, c_m_tvalid, exp_r, (qd.size() != 0));
      end
      prev_stall = (qd.size() != 0) && !c_m_tready;
      prev_d = c_m_tdata;
      if (qd.size() != 0) begin
        checks++;
        if (c_m_tdata !== qd[0] || c_m_tlast !== ql[0]) begin
          errors++;
          $display("FAIL r3_beat: got d=%h l=%b want d=%h l=%b",
                   c_m_tdata, c_m_tlast, qd[0], ql[0]);
        end
        if (c_m_tready) begin
          void'(qd.pop_front());
          void'(ql.pop_front());
        end
      end
      acc = c_s_tvalid && exp_r;
      if (acc) begin
        for (int i = 0; i < 3; i++) begin
          qd.push_back(5'(c_s_tdata >> (5 * i)));
          ql.push_back(i == 2);
        end
        sent++;
      end
    end
    c_s_tvalid = 1'b0;
    c_m_tready = 1'b0;
    checks++;
    if (cyc >= 20000 || sent != 500) begin
      errors++;
      $display("FAIL r3_done: got sent=%0d cyc=%0d want sent=500 cyc<20000",
               sent, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_ratio1_random();
    test_ratio3_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
